// File: rtl/isa_pkg.sv
// Shared ISA constants for the instruction encoder and the control decoder:
// request kinds, MIPS opcode/funct values and the encoder FSM state encoding.
package isa_pkg;

    typedef enum logic [4:0] {
        KIND_ADD  = 5'd0,
        KIND_SUB  = 5'd1,
        KIND_AND  = 5'd2,
        KIND_OR   = 5'd3,
        KIND_SLT  = 5'd4,
        KIND_SLTU = 5'd5,
        KIND_ADDU = 5'd6,
        KIND_SUBU = 5'd7,
        KIND_NOR  = 5'd8,
        KIND_SLL  = 5'd9,
        KIND_ADDI = 5'd10,
        KIND_ORI  = 5'd11,
        KIND_ANDI = 5'd12,
        KIND_LW   = 5'd13,
        KIND_SW   = 5'd14,
        KIND_BEQ  = 5'd15,
        KIND_J    = 5'd16,
        KIND_JAL  = 5'd17
    } kind_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/instr_fmt.sv
// Combinational formatter: instruction kind plus raw fields to a 32-bit MIPS word.
// Fields a format does not use are zeroed; unknown kinds yield a nop and flag illegal.
module instr_fmt
    import isa_pkg::*;
(
    input  logic [4:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    kind_e      kind_sel;
    logic [5:0] op;
    logic [5:0] funct;
    logic       is_r;
    logic       is_i;
    logic       is_j;

    assign kind_sel = kind_e'(kind);

    always_comb begin
        op      = OP_RTYPE;
        funct   = FUNCT_SLL;
        is_r    = 1'b0;
        is_i    = 1'b0;
        is_j    = 1'b0;
        illegal = 1'b0;
        case (kind_sel)
            KIND_ADD:  begin is_r = 1'b1; funct = FUNCT_ADD;  end
            KIND_SUB:  begin is_r = 1'b1; funct = FUNCT_SUB;  end
            KIND_AND:  begin is_r = 1'b1; funct = FUNCT_AND;  end
            KIND_OR:   begin is_r = 1'b1; funct = FUNCT_OR;   end
            KIND_SLT:  begin is_r = 1'b1; funct = FUNCT_SLT;  end
            KIND_SLTU: begin is_r = 1'b1; funct = FUNCT_SLTU; end
            KIND_ADDU: begin is_r = 1'b1; funct = FUNCT_ADDU; end
            KIND_SUBU: begin is_r = 1'b1; funct = FUNCT_SUBU; end
            KIND_NOR:  begin is_r = 1'b1; funct = FUNCT_NOR;  end
            KIND_SLL:  begin is_r = 1'b1; funct = FUNCT_SLL;  end
            KIND_ADDI: begin is_i = 1'b1; op = OP_ADDI; end
            KIND_ORI:  begin is_i = 1'b1; op = OP_ORI;  end
            KIND_ANDI: begin is_i = 1'b1; op = OP_ANDI; end
            KIND_LW:   begin is_i = 1'b1; op = OP_LW;   end
            KIND_SW:   begin is_i = 1'b1; op = OP_SW;   end
            KIND_BEQ:  begin is_i = 1'b1; op = OP_BEQ;  end
            KIND_J:    begin is_j = 1'b1; op = OP_J;    end
            KIND_JAL:  begin is_j = 1'b1; op = OP_JAL;  end
            default:   illegal = 1'b1;
        endcase
    end

    // Only sll carries a shift amount, and it never has an rs operand.
    always_comb begin
        word = 32'h0000_0000;
        if (is_r) begin
            if (kind_sel == KIND_SLL) begin
                word = {OP_RTYPE, 5'd0, rt, rd, shamt, funct};
            end else begin
                word = {OP_RTYPE, rs, rt, rd, 5'd0, funct};
            end
        end else if (is_i) begin
            word = {op, rs, rt, imm[15:0]};
        end else if (is_j) begin
            word = {op, imm};
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Accepts symbolic instruction requests and writes the encoded words to
// consecutive instruction-memory addresses through a write/ack handshake.
module instr_encoder
    import isa_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    input  logic              im_ack,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE     = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_reg;
    state_e            state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [ADDR_W:0]   count_reg;
    logic              err_reg;
    logic              last_reg;

    logic [31:0] fmt_word;
    logic        fmt_illegal;
    logic        overflow;
    logic        restart;
    logic        accept;
    logic        ack_fire;

    instr_fmt u_fmt (
        .kind    (in_kind),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .shamt   (in_shamt),
        .imm     (in_imm),
        .word    (fmt_word),
        .illegal (fmt_illegal)
    );

    assign overflow = (count_reg == CAPACITY);
    assign restart  = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign accept   = in_ready && in_valid;
    assign ack_fire = im_we && im_ack;

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        im_we      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) state_next = overflow ? ST_DONE : ST_WRITE;
            end
            ST_WRITE: begin
                im_we = 1'b1;
                if (im_ack) state_next = last_reg ? ST_DONE : ST_ACCEPT;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_next = ST_ACCEPT;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            addr_reg  <= BASE;
            wdata_reg <= '0;
            count_reg <= '0;
            err_reg   <= 1'b0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (restart) begin
                err_reg   <= 1'b0;
                count_reg <= '0;
                addr_reg  <= BASE;
            end
            // A full program swallows the request: nothing is written, only err records it.
            if (accept) begin
                if (overflow) begin
                    err_reg <= 1'b1;
                end else begin
                    wdata_reg <= fmt_word;
                    last_reg  <= in_last;
                    if (fmt_illegal) err_reg <= 1'b1;
                end
            end
            if (ack_fire) begin
                count_reg <= count_reg + 1'b1;
                addr_reg  <= addr_reg + 1'b1;
            end
        end
    end

    assign im_addr  = addr_reg;
    assign im_wdata = wdata_reg;
    assign count    = count_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder with a 4-word program space,
// compared against an arithmetic model of the MIPS encoding and write sequence.
module tb_instr_encoder;

    localparam int ADDR_W = 2;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4:0]        in_kind = '0;
    logic [4:0]        in_rs = '0;
    logic [4:0]        in_rt = '0;
    logic [4:0]        in_rd = '0;
    logic [4:0]        in_shamt = '0;
    logic [25:0]       in_imm = '0;
    logic              in_last = 1'b0;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              im_ack = 1'b0;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   count;

    int checks = 0;
    int errors = 0;

    int m_count;
    int m_addr;
    bit m_err;
    logic [31:0] seen_word;

    int unsigned funct_tab [10] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A,
                                    32'h2B, 32'h21, 32'h23, 32'h27, 32'h00};
    int unsigned op_tab [8]     = '{32'h08, 32'h0D, 32'h0C, 32'h23, 32'h2B,
                                    32'h04, 32'h02, 32'h03};

    instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_kind  (in_kind),
        .in_rs    (in_rs),
        .in_rt    (in_rt),
        .in_rd    (in_rd),
        .in_shamt (in_shamt),
        .in_imm   (in_imm),
        .in_last  (in_last),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .im_ack   (im_ack),
        .done     (done),
        .err      (err),
        .count    (count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Kinds 0..9 are R-type, 10..15 I-type, 16..17 J-type; anything above is illegal.
    function automatic int unsigned ref_word(int kind, int rs, int rt, int rd, int sh, int unsigned imm);
        int unsigned w;
        w = 0;
        if (kind <= 9) begin
            w = funct_tab[kind] + rt * 65536 + rd * 2048;
            if (kind == 9) w = w + sh * 64;
            else           w = w + rs * 2097152;
        end else if (kind <= 15) begin
            w = op_tab[kind-10] * 67108864 + rs * 2097152 + rt * 65536 + (imm % 65536);
        end else if (kind <= 17) begin
            w = op_tab[kind-10] * 67108864 + (imm % 67108864);
        end
        return w;
    endfunction

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_count = 0;
        m_addr  = 0;
        m_err   = 1'b0;
        chk("start_ready", in_ready, 1);
        chk("start_done", done, 0);
        chk("start_err", err, 0);
        chk("start_count", count, 0);
        chk("start_addr", im_addr, 0);
    endtask

    task automatic send(input int kind, input int rs, input int rt, input int rd, input int sh,
                        input int unsigned imm, input bit last, input int delay, input bit poke);
        int n;
        int unsigned exp_w;
        n = 0;
        while (!in_ready && n < 16) begin
            tick();
            n++;
        end
        chk("ready", in_ready, 1);
        in_kind  = kind[4:0];
        in_rs    = rs[4:0];
        in_rt    = rt[4:0];
        in_rd    = rd[4:0];
        in_shamt = sh[4:0];
        in_imm   = imm[25:0];
        in_last  = last;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (m_count == CAP) begin
            m_err = 1'b1;
            $display("txn kind=%0d overflow count=%0d", kind, m_count);
            chk("ovf_we", im_we, 0);
            chk("ovf_done", done, 1);
            chk("ovf_err", err, 1);
            chk("ovf_count", count, m_count);
            return;
        end
        exp_w = ref_word(kind, rs, rt, rd, sh, imm);
        if (kind > 17) m_err = 1'b1;
        seen_word = im_wdata;
        $display("txn kind=%0d addr=%0d word=%h exp=%h", kind, im_addr, im_wdata, exp_w);
        chk("we", im_we, 1);
        chk("addr", im_addr, m_addr);
        chk("wdata", im_wdata, exp_w);
        chk("busy_ready", in_ready, 0);
        chk("err_acc", err, m_err);
        for (int i = 0; i < delay; i++) begin
            if (poke && i == 0) start = 1'b1;
            tick();
            start = 1'b0;
            chk("hold_we", im_we, 1);
            chk("hold_addr", im_addr, m_addr);
            chk("hold_wdata", im_wdata, exp_w);
            chk("hold_ready", in_ready, 0);
        end
        im_ack = 1'b1;
        tick();
        im_ack = 1'b0;
        m_count++;
        m_addr = (m_addr + 1) % CAP;
        chk("count", count, m_count);
        chk("done", done, last);
        chk("err", err, m_err);
        chk("we_after", im_we, 0);
    endtask

    initial begin
        int len;
        int kind;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_we", im_we, 0);
        end
        in_valid = 1'b0;
        chk("rst_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", im_addr, 0);
        chk("rst_wdata", im_wdata, 0);
        chk("rst_count", count, 0);

        rstn = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("idle_ready", in_ready, 0);
        chk("idle_we", im_we, 0);

        do_start();
        send(10, 0, 8, 0, 0, 32'h0005, 1'b1, 0, 1'b0);
        chk("spec_addi", seen_word, 32'h2008_0005);
        chk("addi_done", done, 1);

        // Requests presented in DONE must be left alone.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("done_we", im_we, 0);
        chk("done_hold", done, 1);
        chk("done_count", count, 1);

        do_start();
        send(0, 9, 10, 8, 0, 0, 1'b0, 3, 1'b1);
        chk("spec_add", seen_word, 32'h012A_4020);
        send(9, 7, 9, 8, 4, 0, 1'b1, 0, 1'b0);
        chk("spec_sll", seen_word, 32'h0009_4100);

        do_start();
        send(16, 0, 0, 0, 0, 32'h0100000, 1'b0, 1, 1'b0);
        chk("spec_j", seen_word, 32'h0810_0000);
        send(31, 3, 4, 5, 6, 32'h1234, 1'b0, 0, 1'b0);
        chk("spec_bad", seen_word, 32'h0000_0000);
        send(17, 0, 0, 0, 0, 3, 1'b1, 0, 1'b0);
        chk("spec_jal", seen_word, 32'h0C00_0003);
        chk("bad_err", err, 1);

        do_start();
        for (int i = 0; i < 4; i++) begin
            send($urandom_range(0, 17), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom, 1'b0,
                 $urandom_range(0, 2), 1'b0);
        end
        send(1, 1, 2, 3, 0, 0, 1'b0, 0, 1'b0);
        do_start();

        for (int p = 0; p < 25; p++) begin
            do_start();
            len = $urandom_range(1, CAP);
            for (int j = 0; j < len; j++) begin
                kind = ($urandom_range(0, 7) == 0) ? $urandom_range(18, 31) : $urandom_range(0, 17);
                send(kind, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom, (j == len - 1), $urandom_range(0, 3),
                     $urandom_range(0, 1));
            end
        end

        // Reset while a write is outstanding abandons it immediately.
        do_start();
        in_kind  = 5'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mid_we", im_we, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_start_we", im_we, 1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mid_rst_we", im_we, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_addr", im_addr, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ready", in_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
